input_buffer_writer: RTL and testbench



---
 rtl/input_buffer_writer_if.sv | 22 ++
 rtl/input_buffer_writer.sv | 64 ++++++
 tb/tb_input_buffer_writer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/input_buffer_writer_if.sv
// input_buffer_writer_if: serial bit stream, bank read port and write status for input_buffer_writer
interface input_buffer_writer_if;
  logic waddr_rst_i;
  logic bit_vld_i;
  logic bit_i;
  logic [3:0] rdata_regnum_i;
  logic [2:0] rdata_regbit_i;
  logic rdata_bit_o;
  logic [3:0] wr_regnum_o;
  logic [2:0] wr_regbit_o;
  logic byte_done_o;
  logic full_o;
  logic overflow_o;
  modport master(
    output waddr_rst_i, bit_vld_i, bit_i, rdata_regnum_i, rdata_regbit_i,
    input rdata_bit_o, wr_regnum_o, wr_regbit_o, byte_done_o, full_o, overflow_o
  );
  modport slave(
    input waddr_rst_i, bit_vld_i, bit_i, rdata_regnum_i, rdata_regbit_i,
    output rdata_bit_o, wr_regnum_o, wr_regbit_o, byte_done_o, full_o, overflow_o
  );
endinterface

// File: rtl/input_buffer_writer.sv
// input_buffer_writer: packs an MSB-first bit stream into bytes stored in a register bank with a registered bit read port
// Ports: SYS_CLK clock, SYS_NRST async active-low reset, bus (slave) carries bit stream in,
// write pointer reset, bank read address/data and write status (regnum, regbit, byte_done, full, overflow).
module input_buffer_writer #(
  parameter int NUM_REG = 16
) (
  input logic SYS_CLK,
  input logic SYS_NRST,
  input_buffer_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECV, FULL} state_t;
  localparam logic [3:0] LAST = 4'(NUM_REG - 1);
  localparam logic [4:0] NREG = 5'(NUM_REG);
  state_t st, st_nx;
  logic [6:0] shift;
  logic [7:0] bank [16];
  logic [3:0] regnum;
  logic [2:0] regbit;
  logic accept, commit, byte_done, overflow, rdata;
  always_ff @(posedge SYS_CLK or negedge SYS_NRST)
    if (!SYS_NRST) st <= IDLE;
    else st <= st_nx;
  // pointer reset wins over a same-cycle bit; bits arriving while FULL are dropped
  always_comb begin
    accept = bus.bit_vld_i && !bus.waddr_rst_i && st != FULL;
    commit = accept && st == RECV && regbit == 3'd0;
    st_nx = bus.waddr_rst_i ? IDLE :
            (st == IDLE && accept) ? RECV :
            commit ? (regnum == LAST ? FULL : IDLE) : st;
  end
  always_ff @(posedge SYS_CLK or negedge SYS_NRST)
    if (!SYS_NRST) begin
      regnum <= '0;
      regbit <= 3'd7;
      shift <= '0;
      byte_done <= 1'b0;
      overflow <= 1'b0;
      rdata <= 1'b0;
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else begin
      byte_done <= commit;
      rdata <= ({1'b0, bus.rdata_regnum_i} < NREG) && bank[bus.rdata_regnum_i][bus.rdata_regbit_i];
      if (commit) bank[regnum] <= {shift, bus.bit_i};
      if (bus.waddr_rst_i) begin
        regnum <= '0;
        regbit <= 3'd7;
        shift <= '0;
        overflow <= 1'b0;
      end else begin
        if (accept) regbit <= regbit - 3'd1;
        if (accept) shift <= {shift[5:0], bus.bit_i};
        if (commit && regnum != LAST) regnum <= regnum + 4'd1;
        if (st == FULL && bus.bit_vld_i) overflow <= 1'b1;
      end
    end
  always_comb begin
    bus.full_o = st == FULL;
    bus.wr_regnum_o = regnum;
    bus.wr_regbit_o = regbit;
    bus.byte_done_o = byte_done;
    bus.overflow_o = overflow;
    bus.rdata_bit_o = rdata;
  end
endmodule

// File: tb/tb_input_buffer_writer.sv
// tb_input_buffer_writer: directed checks of byte packing, bank readback, fill/overflow and resets
module tb_input_buffer_writer;
  logic SYS_CLK, SYS_NRST;
  int checks = 0, errors = 0;
  logic [7:0] v;
  logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  input_buffer_writer_if bus();
  input_buffer_writer #(.NUM_REG(4)) dut (.SYS_CLK(SYS_CLK), .SYS_NRST(SYS_NRST), .bus(bus.slave));
  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;
  task chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task st6(input string tag, input logic [3:0] n, input logic [2:0] b, input logic d, input logic f, input logic o);
    chk({tag, ".regnum"}, 8'(bus.wr_regnum_o), 8'(n));
    chk({tag, ".regbit"}, 8'(bus.wr_regbit_o), 8'(b));
    chk({tag, ".done"}, 8'(bus.byte_done_o), 8'(d));
    chk({tag, ".full"}, 8'(bus.full_o), 8'(f));
    chk({tag, ".ovf"}, 8'(bus.overflow_o), 8'(o));
  endtask
  task put(input logic b);
    @(negedge SYS_CLK);
    bus.bit_vld_i = 1'b1;
    bus.bit_i = b;
  endtask
  task idle();
    @(negedge SYS_CLK);
    bus.bit_vld_i = 1'b0;
    bus.waddr_rst_i = 1'b0;
  endtask
  task send(input logic [7:0] x);
    for (int i = 7; i >= 0; i--) put(x[i]);
  endtask
  task prst();
    @(negedge SYS_CLK);
    bus.bit_vld_i = 1'b0;
    bus.waddr_rst_i = 1'b1;
    idle();
  endtask
  task rdbyte(input logic [3:0] n, output logic [7:0] x);
    for (int i = 7; i >= 0; i--) begin
      @(negedge SYS_CLK);
      bus.rdata_regnum_i = n;
      bus.rdata_regbit_i = 3'(i);
      @(negedge SYS_CLK);
      x[i] = bus.rdata_bit_o;
    end
  endtask
  initial begin
    SYS_NRST = 1'b0;
    bus.waddr_rst_i = 1'b0;
    bus.bit_vld_i = 1'b0;
    bus.bit_i = 1'b0;
    bus.rdata_regnum_i = '0;
    bus.rdata_regbit_i = '0;
    repeat (2) @(negedge SYS_CLK);
    st6("reset", 4'd0, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("reset.rdata", 8'(bus.rdata_bit_o), 8'h00);
    SYS_NRST = 1'b1;
    send(8'hA5);
    idle();
    st6("a5", 4'd1, 3'd7, 1'b1, 1'b0, 1'b0);
    idle();
    chk("a5.done_once", 8'(bus.byte_done_o), 8'h00);
    rdbyte(4'd0, v);
    chk("a5.read", v, 8'hA5);
    send(8'h3C);
    idle();
    repeat (5) put(1'b1);
    idle();
    st6("part", 4'd2, 3'd2, 1'b0, 1'b0, 1'b0);
    prst();
    st6("prst", 4'd0, 3'd7, 1'b0, 1'b0, 1'b0);
    send(8'h0F);
    idle();
    st6("0f", 4'd1, 3'd7, 1'b1, 1'b0, 1'b0);
    rdbyte(4'd0, v);
    chk("0f.read0", v, 8'h0F);
    rdbyte(4'd1, v);
    chk("0f.keep1", v, 8'h3C);
    prst();
    repeat (7) put(1'b1);
    @(negedge SYS_CLK);
    bus.bit_vld_i = 1'b1;
    bus.bit_i = 1'b1;
    bus.waddr_rst_i = 1'b1;
    idle();
    st6("simul", 4'd0, 3'd7, 1'b0, 1'b0, 1'b0);
    rdbyte(4'd0, v);
    chk("simul.keep0", v, 8'h0F);
    send(8'hAA);
    send(8'hBB);
    repeat (7) put(1'b0);
    @(negedge SYS_CLK);
    bus.rdata_regnum_i = 4'd2;
    bus.rdata_regbit_i = 3'd0;
    bus.bit_vld_i = 1'b1;
    bus.bit_i = 1'b1;
    idle();
    chk("coll.old", 8'(bus.rdata_bit_o), 8'h00);
    chk("coll.done", 8'(bus.byte_done_o), 8'h01);
    @(negedge SYS_CLK);
    chk("coll.new", 8'(bus.rdata_bit_o), 8'h01);
    chk("coll.regnum", 8'(bus.wr_regnum_o), 8'h03);
    prst();
    for (int i = 0; i < 4; i++) send(fill[i]);
    idle();
    st6("fill", 4'd3, 3'd7, 1'b1, 1'b1, 1'b0);
    put(1'b1);
    put(1'b0);
    put(1'b1);
    idle();
    st6("ovf", 4'd3, 3'd7, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rdbyte(4'(i), v);
      chk("ovf.bank", v, fill[i]);
    end
    rdbyte(4'd5, v);
    chk("oob.read", v, 8'h00);
    prst();
    st6("clr", 4'd0, 3'd7, 1'b0, 1'b0, 1'b0);
    send(8'h5A);
    bus.rdata_regnum_i = 4'd0;
    bus.rdata_regbit_i = 3'd6;
    put(1'b1);
    put(1'b1);
    put(1'b1);
    idle();
    chk("pre.rdata", 8'(bus.rdata_bit_o), 8'h01);
    chk("pre.regbit", 8'(bus.wr_regbit_o), 8'h04);
    #2 SYS_NRST = 1'b0;
    #1 st6("arst", 4'd0, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("arst.rdata", 8'(bus.rdata_bit_o), 8'h00);
    @(negedge SYS_CLK);
    SYS_NRST = 1'b1;
    rdbyte(4'd0, v);
    chk("arst.bank0", v, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
